mac_violation_handler: RTL and testbench
========================================

Name: mac_violation_handler

Overview:
- Responder side of the secure-section access monitor.
- Consumes the monitor's per-class violation flags and logs the first violation: cause, PC and address.
- Holds the CPU in reset for a fixed window, then scrubs the secure data section word-by-word through a granted memory write port, then releases the CPU.
- Sits between the access monitor and the openMSP430 reset input / data-memory arbiter.

Parameters:
- SDATA_START, 16'h0500, first byte address of the secure data section (word aligned).
- SDATA_STOP, 16'h0C00, last byte address of the secure data section (inclusive, word aligned).
- RST_CYCLES, 16, CPU reset hold cycles before scrubbing starts (>=1).
- SCRUB_EN, 1, 0 skips the SCRUB state (HOLD goes straight to RELEASE).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- viol_data  in  1  invalid secure data access this cycle
- viol_text  in  1  invalid secure text access this cycle
- viol_write  in  1  write to secure text this cycle
- viol_jmp  in  1  jump into secure text at a non-entry address this cycle
- viol_pc  in  16  CPU pc in the violating cycle
- viol_addr  in  16  data/code address in the violating cycle
- clear_log  in  1  pulse; clears the log registers (honoured only in IDLE)
- scrub_gnt  in  1  arbiter accepts the current scrub write
- scrub_wr  out  1  scrub write request
- scrub_addr  out  16  scrub byte address
- scrub_wdata  out  16  scrub data, constant 16'h0000
- cpu_rst  out  1  active-high reset to the CPU
- busy  out  1  FSM not in IDLE
- log_valid  out  1  log holds a recorded violation
- log_cause  out  4  {jmp, write, text, data} flags of the logged violation
- log_pc  out  16  logged pc
- log_addr  out  16  logged address
- viol_count  out  8  violations accepted since reset, saturating at 255
- overrun  out  1  sticky; a violation arrived while busy

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All outputs 0, including log_*, viol_count and overrun.
  - Reset applies mid-sequence too: scrub_wr drops on the next edge and the scrub is abandoned.
- any_viol = OR of the four viol_* inputs.
- IDLE:
  - On any_viol, on the same edge:
    - capture log_cause/log_pc/log_addr;
    - set log_valid=1;
    - increment viol_count (saturating);
    - load hold counter with RST_CYCLES-1;
    - go to HOLD.
  - cpu_rst is registered: it goes high the cycle after the violation (1-cycle latency).
  - clear_log in IDLE without any_viol: log_valid, log_cause, log_pc, log_addr and overrun go to 0. viol_count is kept.
  - clear_log and any_viol in the same cycle: the violation wins and the log is overwritten.
- HOLD:
  - cpu_rst=1. The counter decrements each cycle.
  - At 0: go to SCRUB with scrub_addr=SDATA_START if SCRUB_EN=1, else go to RELEASE.
  - cpu_rst stays high for exactly RST_CYCLES cycles in HOLD.
- SCRUB:
  - cpu_rst=1, scrub_wr=1, scrub_wdata=0.
  - Request rule: scrub_addr and scrub_wr stay stable until a cycle with scrub_gnt=1.
  - On grant: if scrub_addr==SDATA_STOP go to RELEASE (scrub_wr=0 next cycle); else scrub_addr+=2.
  - Address compare is exact equality. Bounds are word aligned, so there is no overshoot.
  - Use 16-bit unsigned arithmetic. SDATA_STOP < SDATA_START is illegal (elaboration check).
  - Defaults give 897 writes.
- RELEASE:
  - One cycle with cpu_rst=0 and busy=1, then IDLE.
  - Any violation in this cycle counts as an overrun.
- Violations while busy (HOLD/SCRUB/RELEASE):
  - do not re-trigger and do not overwrite the log;
  - set overrun=1 and increment viol_count (saturating).
- A violation in the first IDLE cycle after RELEASE starts a new sequence normally.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, HOLD=2'd1, SCRUB=2'd2, RELEASE=2'd3;
  - cause bit indices: DATA=0, TEXT=1, WRITE=2, JMP=3;
  - the secure-section default address constants, shared with the access monitor.
- One natural sub-module: mac_scrub_seq. It is the address generator plus request/grant handshake, with a start/done interface. The FSM and log stay in the top.

Test Plan:
- viol_data=1 for 1 cycle, viol_pc=16'h8010, viol_addr=16'h0600 -> next cycle:
  - log_cause=4'b0001, log_pc=8010, log_addr=0600, viol_count=1, cpu_rst=1.
  - cpu_rst is held for 16 HOLD cycles.
- SCRUB with scrub_gnt tied 1 (defaults) -> 897 writes of 0 at 0500,0502..0C00, then a 1-cycle RELEASE with cpu_rst=0, then IDLE.
- scrub_gnt toggling 1,0,0,1 -> scrub_addr and scrub_wr stay stable during the low cycles, and no address is skipped or repeated.
- viol_jmp during HOLD and again during SCRUB -> overrun=1, viol_count=3, log_cause still 4'b0001.
- rst_n=0 during SCRUB at scrub_addr=0700 -> next edge: all outputs 0, state IDLE. A following viol_text restarts from HOLD.
- SCRUB_EN=0, RST_CYCLES=1 -> cpu_rst high for 1 cycle, then RELEASE, with no scrub_wr at any time.
- clear_log in IDLE -> log_valid=0 and overrun=0, viol_count kept. clear_log with viol_write in the same cycle -> log_cause=4'b0100.

Source files
------------

// File: rtl/mac_violation_handler_pkg.sv
// Shared definitions for the secure-section violation handler:
// FSM state encoding, violation cause bit positions, default secure-section
// bounds (also used by the access monitor) and a saturating counter helper.
package mac_violation_handler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_SCRUB   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int unsigned CAUSE_DATA  = 0;
  localparam int unsigned CAUSE_TEXT  = 1;
  localparam int unsigned CAUSE_WRITE = 2;
  localparam int unsigned CAUSE_JMP   = 3;

  localparam logic [15:0] SDATA_START_DEFAULT = 16'h0500;
  localparam logic [15:0] SDATA_STOP_DEFAULT  = 16'h0C00;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mac_violation_handler_if.sv
// Signal bundle between the access monitor / memory arbiter / CPU side and
// the violation handler.
//   slave  : the handler (consumes violation flags and grant, drives
//            scrub write port, CPU reset, status and log)
//   master : the environment driving violations and the grant
interface mac_violation_handler_if;

  logic        viol_data;
  logic        viol_text;
  logic        viol_write;
  logic        viol_jmp;
  logic [15:0] viol_pc;
  logic [15:0] viol_addr;
  logic        clear_log;
  logic        scrub_gnt;

  logic        scrub_wr;
  logic [15:0] scrub_addr;
  logic [15:0] scrub_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        log_valid;
  logic [3:0]  log_cause;
  logic [15:0] log_pc;
  logic [15:0] log_addr;
  logic [7:0]  viol_count;
  logic        overrun;

  modport slave (
    input  viol_data, viol_text, viol_write, viol_jmp, viol_pc, viol_addr,
           clear_log, scrub_gnt,
    output scrub_wr, scrub_addr, scrub_wdata, cpu_rst, busy, log_valid,
           log_cause, log_pc, log_addr, viol_count, overrun
  );

  modport master (
    output viol_data, viol_text, viol_write, viol_jmp, viol_pc, viol_addr,
           clear_log, scrub_gnt,
    input  scrub_wr, scrub_addr, scrub_wdata, cpu_rst, busy, log_valid,
           log_cause, log_pc, log_addr, viol_count, overrun
  );

endinterface

// File: rtl/mac_violation_handler_scrub_seq.sv
// Scrub address generator with request/grant handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   i_start    : load SDATA_START and begin requesting
//   i_gnt      : arbiter accepted the current write
//   o_wr       : write request (held until granted)
//   o_addr     : byte address of the current write
//   o_done     : last word (SDATA_STOP) granted this cycle
module mac_scrub_seq #(
  parameter logic [15:0] SDATA_START = 16'h0500,
  parameter logic [15:0] SDATA_STOP  = 16'h0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_gnt,
  output logic        o_wr,
  output logic [15:0] o_addr,
  output logic        o_done
);

  logic        r_active;
  logic [15:0] r_addr;
  logic        w_last;

  assign w_last = (r_addr == SDATA_STOP);
  assign o_done = r_active & i_gnt & w_last;
  assign o_wr   = r_active;
  assign o_addr = r_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_addr   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_addr   <= SDATA_START;
    end else if (r_active && i_gnt) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_addr   <= '0;
      end else begin
        r_addr <= r_addr + 16'd2;
      end
    end
  end

endmodule

// File: rtl/mac_violation_handler.sv
// Secure-section violation responder: logs the first violation, holds the
// CPU in reset, scrubs the secure data section, then releases the CPU.
//   clk, rst_n : clock, synchronous active-low reset
//   vh         : violation inputs, scrub write port, CPU reset, status, log
module mac_violation_handler
  import mac_violation_handler_pkg::*;
#(
  parameter logic [15:0] SDATA_START = SDATA_START_DEFAULT,
  parameter logic [15:0] SDATA_STOP  = SDATA_STOP_DEFAULT,
  parameter int unsigned RST_CYCLES  = 16,
  parameter bit          SCRUB_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mac_violation_handler_if.slave    vh
);

  if (SDATA_STOP < SDATA_START) begin : g_chk_range
    $error("SDATA_STOP must not be below SDATA_START");
  end
  if (SDATA_START[0] || SDATA_STOP[0]) begin : g_chk_align
    $error("secure data bounds must be word aligned");
  end
  if (RST_CYCLES < 1) begin : g_chk_rst
    $error("RST_CYCLES must be at least 1");
  end

  localparam logic [15:0] HOLD_LOAD = 16'(RST_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hold_cnt;
  logic        r_cpu_rst;
  logic        r_busy;
  logic        r_log_valid;
  logic [3:0]  r_log_cause;
  logic [15:0] r_log_pc;
  logic [15:0] r_log_addr;
  logic [7:0]  r_viol_count;
  logic        r_overrun;

  logic [3:0]  w_viol_vec;
  logic        w_any_viol;
  logic        w_scrub_start;
  logic        w_scrub_done;
  logic        w_scrub_wr;
  logic [15:0] w_scrub_addr;

  always_comb begin
    w_viol_vec              = '0;
    w_viol_vec[CAUSE_DATA]  = vh.viol_data;
    w_viol_vec[CAUSE_TEXT]  = vh.viol_text;
    w_viol_vec[CAUSE_WRITE] = vh.viol_write;
    w_viol_vec[CAUSE_JMP]   = vh.viol_jmp;
  end

  assign w_any_viol = |w_viol_vec;

  mac_scrub_seq #(
    .SDATA_START (SDATA_START),
    .SDATA_STOP  (SDATA_STOP)
  ) u_scrub_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_scrub_start),
    .i_gnt   (vh.scrub_gnt),
    .o_wr    (w_scrub_wr),
    .o_addr  (w_scrub_addr),
    .o_done  (w_scrub_done)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_scrub_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_viol) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) begin
          if (SCRUB_EN) begin
            w_state_nxt   = ST_SCRUB;
            w_scrub_start = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
      end
      ST_SCRUB: begin
        if (w_scrub_done) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // cpu_rst/busy are decoded from the next state so they leave a flop
  // directly while still changing together with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_rst <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cpu_rst <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_SCRUB);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_IDLE && w_any_viol) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_state == ST_HOLD && r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 16'd1;
    end
  end

  // Log captures only from IDLE; a violation beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_log_valid  <= 1'b0;
      r_log_cause  <= '0;
      r_log_pc     <= '0;
      r_log_addr   <= '0;
      r_viol_count <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_any_viol) r_viol_count <= sat_inc8(r_viol_count);
      if (r_state == ST_IDLE) begin
        if (w_any_viol) begin
          r_log_valid <= 1'b1;
          r_log_cause <= w_viol_vec;
          r_log_pc    <= vh.viol_pc;
          r_log_addr  <= vh.viol_addr;
        end else if (vh.clear_log) begin
          r_log_valid <= 1'b0;
          r_log_cause <= '0;
          r_log_pc    <= '0;
          r_log_addr  <= '0;
          r_overrun   <= 1'b0;
        end
      end else if (w_any_viol) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign vh.scrub_wr    = w_scrub_wr;
  assign vh.scrub_addr  = w_scrub_addr;
  assign vh.scrub_wdata = '0;
  assign vh.cpu_rst     = r_cpu_rst;
  assign vh.busy        = r_busy;
  assign vh.log_valid   = r_log_valid;
  assign vh.log_cause   = r_log_cause;
  assign vh.log_pc      = r_log_pc;
  assign vh.log_addr    = r_log_addr;
  assign vh.viol_count  = r_viol_count;
  assign vh.overrun     = r_overrun;

endmodule

// File: tb/tb_mac_violation_handler.sv
module tb_mac_violation_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def, rst_ns, rst_sm;

  mac_violation_handler_if if_def ();
  mac_violation_handler_if if_ns ();
  mac_violation_handler_if if_sm ();

  mac_violation_handler u_def (
    .clk   (clk),
    .rst_n (rst_def),
    .vh    (if_def)
  );

  mac_violation_handler #(
    .RST_CYCLES (1),
    .SCRUB_EN   (1'b0)
  ) u_ns (
    .clk   (clk),
    .rst_n (rst_ns),
    .vh    (if_ns)
  );

  mac_violation_handler #(
    .SDATA_START (16'h0100),
    .SDATA_STOP  (16'h0110),
    .RST_CYCLES  (3)
  ) u_sm (
    .clk   (clk),
    .rst_n (rst_sm),
    .vh    (if_sm)
  );

  typedef struct {
    logic [15:0] start;
    logic [15:0] stop;
    int          rcyc;
    bit          sen;
  } cfg_t;

  // Reference: remaining reset-hold cycles, pending scrub address, pending
  // release cycle, plus the log. Busy is "any of the three still pending".
  typedef struct {
    int          hold_left;
    bit          scrub_on;
    int          scrub_next;
    bit          rel_pend;
    bit          log_valid;
    logic [3:0]  cause;
    logic [15:0] pc;
    logic [15:0] addr;
    int          count;
    bit          overrun;
  } mdl_t;

  typedef struct {
    bit          rst_n;
    logic [3:0]  viol;   // {jmp, write, text, data}
    logic [15:0] pc;
    logic [15:0] addr;
    bit          clr;
    bit          gnt;
  } stim_t;

  cfg_t  c_def, c_ns, c_sm;
  mdl_t  m_def, m_ns, m_sm;
  stim_t s_def, s_ns, s_sm;
  int    n_checks = 0;
  int    n_errors = 0;
  bit    ns_saw_wr = 1'b0;

  function automatic bit m_busy(mdl_t m);
    return (m.hold_left > 0) || m.scrub_on || m.rel_pend;
  endfunction

  function automatic mdl_t m_step(mdl_t m, cfg_t c, stim_t s);
    mdl_t n;
    bit   idle;
    n = m;
    if (!s.rst_n) begin
      n = '{default: 0};
      return n;
    end
    idle = !m_busy(m);
    if (s.viol != 4'b0) n.count = (m.count < 255) ? m.count + 1 : 255;
    if (idle) begin
      if (s.viol != 4'b0) begin
        n.log_valid = 1'b1;
        n.cause     = s.viol;
        n.pc        = s.pc;
        n.addr      = s.addr;
        n.hold_left = c.rcyc;
      end else if (s.clr) begin
        n.log_valid = 1'b0;
        n.cause     = '0;
        n.pc        = '0;
        n.addr      = '0;
        n.overrun   = 1'b0;
      end
    end else begin
      if (s.viol != 4'b0) n.overrun = 1'b1;
      if (m.hold_left > 0) begin
        n.hold_left = m.hold_left - 1;
        if (n.hold_left == 0) begin
          if (c.sen) begin
            n.scrub_on   = 1'b1;
            n.scrub_next = int'(c.start);
          end else begin
            n.rel_pend = 1'b1;
          end
        end
      end else if (m.scrub_on) begin
        if (s.gnt) begin
          if (m.scrub_next == int'(c.stop)) begin
            n.scrub_on = 1'b0;
            n.rel_pend = 1'b1;
          end else begin
            n.scrub_next = m.scrub_next + 2;
          end
        end
      end else begin
        n.rel_pend = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.rst_n = 1'b1;
    s.viol  = '0;
    s.pc    = '0;
    s.addr  = '0;
    s.clr   = 1'b0;
    s.gnt   = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 199) != 0);
    s.viol  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
    s.pc    = 16'($urandom);
    s.addr  = 16'($urandom);
    s.clr   = ($urandom_range(0, 7) == 0);
    s.gnt   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_outs(string nm, logic wr, logic [15:0] sa, logic [15:0] wd,
                          logic cr, logic bz, logic lv, logic [3:0] lc,
                          logic [15:0] lp, logic [15:0] la, logic [7:0] vc,
                          logic ov, mdl_t m);
    chk({nm, ".scrub_wr"}, wr, m.scrub_on);
    if (m.scrub_on) chk({nm, ".scrub_addr"}, sa, m.scrub_next);
    chk({nm, ".scrub_wdata"}, wd, 0);
    chk({nm, ".cpu_rst"}, cr, (m.hold_left > 0) || m.scrub_on);
    chk({nm, ".busy"}, bz, m_busy(m));
    chk({nm, ".log_valid"}, lv, m.log_valid);
    chk({nm, ".log_cause"}, lc, m.cause);
    chk({nm, ".log_pc"}, lp, m.pc);
    chk({nm, ".log_addr"}, la, m.addr);
    chk({nm, ".viol_count"}, vc, m.count);
    chk({nm, ".overrun"}, ov, m.overrun);
  endtask

  task automatic drive();
    rst_def           = s_def.rst_n;
    if_def.viol_data  = s_def.viol[0];
    if_def.viol_text  = s_def.viol[1];
    if_def.viol_write = s_def.viol[2];
    if_def.viol_jmp   = s_def.viol[3];
    if_def.viol_pc    = s_def.pc;
    if_def.viol_addr  = s_def.addr;
    if_def.clear_log  = s_def.clr;
    if_def.scrub_gnt  = s_def.gnt;
    rst_ns            = s_ns.rst_n;
    if_ns.viol_data   = s_ns.viol[0];
    if_ns.viol_text   = s_ns.viol[1];
    if_ns.viol_write  = s_ns.viol[2];
    if_ns.viol_jmp    = s_ns.viol[3];
    if_ns.viol_pc     = s_ns.pc;
    if_ns.viol_addr   = s_ns.addr;
    if_ns.clear_log   = s_ns.clr;
    if_ns.scrub_gnt   = s_ns.gnt;
    rst_sm            = s_sm.rst_n;
    if_sm.viol_data   = s_sm.viol[0];
    if_sm.viol_text   = s_sm.viol[1];
    if_sm.viol_write  = s_sm.viol[2];
    if_sm.viol_jmp    = s_sm.viol[3];
    if_sm.viol_pc     = s_sm.pc;
    if_sm.viol_addr   = s_sm.addr;
    if_sm.clear_log   = s_sm.clr;
    if_sm.scrub_gnt   = s_sm.gnt;
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    m_def = m_step(m_def, c_def, s_def);
    m_ns  = m_step(m_ns, c_ns, s_ns);
    m_sm  = m_step(m_sm, c_sm, s_sm);
    @(negedge clk);
    if (if_ns.scrub_wr) ns_saw_wr = 1'b1;
    cmp_outs("def", if_def.scrub_wr, if_def.scrub_addr, if_def.scrub_wdata, if_def.cpu_rst,
             if_def.busy, if_def.log_valid, if_def.log_cause, if_def.log_pc, if_def.log_addr,
             if_def.viol_count, if_def.overrun, m_def);
    cmp_outs("ns", if_ns.scrub_wr, if_ns.scrub_addr, if_ns.scrub_wdata, if_ns.cpu_rst,
             if_ns.busy, if_ns.log_valid, if_ns.log_cause, if_ns.log_pc, if_ns.log_addr,
             if_ns.viol_count, if_ns.overrun, m_ns);
    cmp_outs("sm", if_sm.scrub_wr, if_sm.scrub_addr, if_sm.scrub_wdata, if_sm.cpu_rst,
             if_sm.busy, if_sm.log_valid, if_sm.log_cause, if_sm.log_pc, if_sm.log_addr,
             if_sm.viol_count, if_sm.overrun, m_sm);
  endtask

  task automatic drain_def(string tag);
    s_def = quiet();
    s_def.gnt = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (!if_def.busy) break;
      tick();
    end
    chk(tag, if_def.busy, 0);
  endtask

  initial begin
    int          hc;
    int          writes;
    logic [15:0] exp_a;
    bit          g;

    c_def = '{start: 16'h0500, stop: 16'h0C00, rcyc: 16, sen: 1'b1};
    c_ns  = '{start: 16'h0500, stop: 16'h0C00, rcyc: 1,  sen: 1'b0};
    c_sm  = '{start: 16'h0100, stop: 16'h0110, rcyc: 3,  sen: 1'b1};
    m_def = '{default: 0};
    m_ns  = '{default: 0};
    m_sm  = '{default: 0};
    s_def = quiet(); s_def.rst_n = 1'b0;
    s_ns  = quiet(); s_ns.rst_n  = 1'b0;
    s_sm  = quiet(); s_sm.rst_n  = 1'b0;
    repeat (3) tick();
    chk("rst.cpu_rst", if_def.cpu_rst, 0);
    chk("rst.busy", if_def.busy, 0);
    chk("rst.viol_count", if_def.viol_count, 0);
    s_def = quiet(); s_ns = quiet(); s_sm = quiet();
    tick();

    // A: data violation, full scrub with grant tied high, overruns in HOLD/SCRUB
    s_def.viol = 4'b0001; s_def.pc = 16'h8010; s_def.addr = 16'h0600;
    tick();
    s_def = quiet(); s_def.gnt = 1'b1;
    chk("A.log_cause", if_def.log_cause, 4'b0001);
    chk("A.log_pc", if_def.log_pc, 16'h8010);
    chk("A.log_addr", if_def.log_addr, 16'h0600);
    chk("A.viol_count", if_def.viol_count, 1);
    chk("A.cpu_rst", if_def.cpu_rst, 1);
    hc = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(if_def.cpu_rst && !if_def.scrub_wr)) break;
      hc++;
      s_def.viol = (k == 4) ? 4'b1000 : 4'b0000;
      tick();
    end
    chk("A.hold_cycles", hc, 16);
    writes = 0;
    exp_a  = 16'h0500;
    for (int k = 0; k < 2000; k++) begin
      if (!if_def.scrub_wr) break;
      chk("A.scrub_addr", if_def.scrub_addr, exp_a);
      writes++;
      exp_a = exp_a + 16'd2;
      s_def.viol = (writes == 10) ? 4'b1000 : 4'b0000;
      tick();
    end
    chk("A.writes", writes, 897);
    chk("A.last_addr", exp_a - 16'd2, 16'h0C00);
    chk("A.release_cpu_rst", if_def.cpu_rst, 0);
    chk("A.release_busy", if_def.busy, 1);
    s_def.viol = 4'b0;
    tick();
    chk("A.idle_busy", if_def.busy, 0);
    chk("A.overrun", if_def.overrun, 1);
    chk("A.viol_count_end", if_def.viol_count, 3);
    chk("A.log_cause_kept", if_def.log_cause, 4'b0001);

    // B: grant pattern 1,0,0,1 -- address must only advance on grant
    s_def = quiet();
    s_def.viol = 4'b0010;
    tick();
    s_def = quiet();
    for (int k = 0; k < 100; k++) begin
      if (if_def.scrub_wr) break;
      tick();
    end
    writes = 0;
    exp_a  = 16'h0500;
    for (int k = 0; k < 4000; k++) begin
      if (!if_def.scrub_wr) break;
      chk("B.scrub_addr", if_def.scrub_addr, exp_a);
      g = ((k % 4) == 0) || ((k % 4) == 3);
      s_def.gnt = g;
      if (g) begin
        writes++;
        exp_a = exp_a + 16'd2;
      end
      tick();
    end
    chk("B.writes", writes, 897);
    drain_def("B.idle");

    // C: reset in the middle of the scrub, then a fresh violation
    s_def = quiet();
    s_def.viol = 4'b0001;
    tick();
    s_def = quiet(); s_def.gnt = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (if_def.scrub_wr && if_def.scrub_addr == 16'h0700) break;
      tick();
    end
    chk("C.reached_0700", if_def.scrub_addr, 16'h0700);
    s_def.rst_n = 1'b0;
    tick();
    s_def = quiet();
    chk("C.scrub_wr", if_def.scrub_wr, 0);
    chk("C.scrub_addr", if_def.scrub_addr, 0);
    chk("C.cpu_rst", if_def.cpu_rst, 0);
    chk("C.busy", if_def.busy, 0);
    chk("C.log_valid", if_def.log_valid, 0);
    chk("C.log_pc", if_def.log_pc, 0);
    chk("C.viol_count", if_def.viol_count, 0);
    chk("C.overrun", if_def.overrun, 0);
    s_def.viol = 4'b0010;
    tick();
    s_def = quiet();
    chk("C.restart_cpu_rst", if_def.cpu_rst, 1);
    chk("C.restart_cause", if_def.log_cause, 4'b0010);
    hc = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(if_def.cpu_rst && !if_def.scrub_wr)) break;
      hc++;
      s_def.viol = (k == 2) ? 4'b0100 : 4'b0000;
      tick();
    end
    chk("C.hold_cycles", hc, 16);
    drain_def("C.idle");

    // D: clear_log alone, then together with a write violation
    s_def = quiet();
    s_def.clr = 1'b1;
    tick();
    chk("D.log_valid", if_def.log_valid, 0);
    chk("D.overrun", if_def.overrun, 0);
    chk("D.viol_count_kept", if_def.viol_count, 2);
    s_def.clr  = 1'b1;
    s_def.viol = 4'b0100;
    tick();
    s_def = quiet();
    chk("D.log_cause", if_def.log_cause, 4'b0100);
    chk("D.log_valid_set", if_def.log_valid, 1);
    drain_def("D.idle");

    // E: no-scrub instance with single-cycle hold
    s_ns = quiet();
    s_ns.viol = 4'b0001;
    tick();
    s_ns = quiet();
    chk("E.hold_cpu_rst", if_ns.cpu_rst, 1);
    tick();
    chk("E.release_cpu_rst", if_ns.cpu_rst, 0);
    chk("E.release_busy", if_ns.busy, 1);
    tick();
    chk("E.idle_busy", if_ns.busy, 0);

    // F: counter saturation
    s_sm = quiet();
    s_sm.gnt = 1'b1;
    s_sm.viol = 4'b1000;
    repeat (300) tick();
    s_sm = quiet();
    chk("F.viol_count_sat", if_sm.viol_count, 255);

    // G: randomized traffic on the small-range and no-scrub instances
    for (int i = 0; i < 4000; i++) begin
      s_sm = rand_stim();
      s_ns = rand_stim();
      tick();
    end
    chk("G.ns_never_scrubs", ns_saw_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
